// File: rtl/keyboard_pkg.sv
// Key byte constants, navigation command encoding and the byte-to-command decoder
// shared by the cursor navigation slice.
package keyboard_pkg;

  localparam int unsigned KEY_BYTE_W = 8;

  localparam logic [KEY_BYTE_W-1:0] KEY_W_UC  = 8'h57;
  localparam logic [KEY_BYTE_W-1:0] KEY_W_LC  = 8'h77;
  localparam logic [KEY_BYTE_W-1:0] KEY_S_UC  = 8'h53;
  localparam logic [KEY_BYTE_W-1:0] KEY_S_LC  = 8'h73;
  localparam logic [KEY_BYTE_W-1:0] KEY_D_UC  = 8'h44;
  localparam logic [KEY_BYTE_W-1:0] KEY_D_LC  = 8'h64;
  localparam logic [KEY_BYTE_W-1:0] KEY_A_UC  = 8'h41;
  localparam logic [KEY_BYTE_W-1:0] KEY_A_LC  = 8'h61;
  localparam logic [KEY_BYTE_W-1:0] KEY_R_UC  = 8'h52;
  localparam logic [KEY_BYTE_W-1:0] KEY_R_LC  = 8'h72;
  localparam logic [KEY_BYTE_W-1:0] KEY_SPACE = 8'h20;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DN,
    CMD_LT,
    CMD_RT,
    CMD_HOME,
    CMD_SEL
  } nav_cmd_t;

  // Case-insensitive WASD/R/space decode; anything else is a no-op command.
  function automatic nav_cmd_t decode_key(input logic [KEY_BYTE_W-1:0] key);
    nav_cmd_t cmd;
    cmd = CMD_NONE;
    case (key)
      KEY_W_UC, KEY_W_LC: cmd = CMD_UP;
      KEY_S_UC, KEY_S_LC: cmd = CMD_DN;
      KEY_D_UC, KEY_D_LC: cmd = CMD_RT;
      KEY_A_UC, KEY_A_LC: cmd = CMD_LT;
      KEY_R_UC, KEY_R_LC: cmd = CMD_HOME;
      KEY_SPACE:          cmd = CMD_SEL;
      default:            cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/nav_fifo.sv
// Single-clock key buffer with async reset; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module nav_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/keyboard_cursor_nav.sv
// Buffers received key bytes, decodes WASD/R/space and moves a bounded (x,y)
// cursor with wrap or saturate behaviour at the edges.
module keyboard_cursor_nav
  import keyboard_pkg::*;
#(
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned X_MIN      = 1,
  parameter int unsigned X_MAX      = 4,
  parameter int unsigned Y_MIN      = 1,
  parameter int unsigned Y_MAX      = 4,
  parameter int unsigned HOME_X     = 1,
  parameter int unsigned HOME_Y     = 1,
  parameter int unsigned STEP       = 1,
  parameter int unsigned WRAP       = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_BYTE_W-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  clr_ovf,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic                  move_pulse,
  output logic                  sel_pulse,
  output logic                  overflow
);

  localparam int unsigned CW1 = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] X_HOME = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] Y_HOME = COORD_W'(HOME_Y);

  logic [KEY_BYTE_W-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic                  pop_c, push_c, drop_c;

  nav_cmd_t              cmd_q, cmd_d;
  logic                  cmd_v_q, cmd_v_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic                  move_q, move_d;
  logic                  sel_q, sel_d;
  logic                  overflow_q, overflow_d;

  // Step up with one guard bit so v+STEP never wraps before the bound test.
  function automatic logic [COORD_W-1:0] step_up(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lo,
                                                 input logic [COORD_W-1:0] hi);
    logic [CW1-1:0]     sum;
    logic [COORD_W-1:0] res;
    sum = {1'b0, v} + CW1'(STEP);
    if (sum > {1'b0, hi}) begin
      res = (WRAP != 0) ? lo : hi;
    end else begin
      res = sum[COORD_W-1:0];
    end
    return res;
  endfunction

  // Compare against MIN+STEP instead of subtracting, so no underflow can occur.
  function automatic logic [COORD_W-1:0] step_dn(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lo,
                                                 input logic [COORD_W-1:0] hi);
    logic [COORD_W-1:0] res;
    if ({1'b0, v} < ({1'b0, lo} + CW1'(STEP))) begin
      res = (WRAP != 0) ? hi : lo;
    end else begin
      res = v - COORD_W'(STEP);
    end
    return res;
  endfunction

  assign pop_c  = !fifo_empty;
  assign push_c = rx_valid && (!fifo_full || pop_c);
  assign drop_c = rx_valid && fifo_full && !pop_c;

  nav_fifo #(
    .WIDTH (KEY_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop stage plus sticky overflow (a drop beats a same-cycle clear).
  always_comb begin
    cmd_d      = CMD_NONE;
    cmd_v_d    = 1'b0;
    overflow_d = overflow_q;
    if (pop_c) begin
      cmd_d   = decode_key(fifo_dout);
      cmd_v_d = 1'b1;
    end
    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Apply stage: one command per cycle, pulses only on real change or select.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    sel_d  = 1'b0;
    move_d = 1'b0;
    if (cmd_v_q) begin
      case (cmd_q)
        CMD_UP:   y_d = step_up(y_q, Y_LO, Y_HI);
        CMD_DN:   y_d = step_dn(y_q, Y_LO, Y_HI);
        CMD_RT:   x_d = step_up(x_q, X_LO, X_HI);
        CMD_LT:   x_d = step_dn(x_q, X_LO, X_HI);
        CMD_HOME: begin
          x_d = X_HOME;
          y_d = Y_HOME;
        end
        CMD_SEL:  sel_d = 1'b1;
        default:  ;
      endcase
    end
    move_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= CMD_NONE;
      cmd_v_q    <= 1'b0;
      x_q        <= X_HOME;
      y_q        <= Y_HOME;
      move_q     <= 1'b0;
      sel_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      cmd_v_q    <= cmd_v_d;
      x_q        <= x_d;
      y_q        <= y_d;
      move_q     <= move_d;
      sel_q      <= sel_d;
      overflow_q <= overflow_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign move_pulse = move_q;
  assign sel_pulse  = sel_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keyboard_cursor_nav.sv
// Bench for keyboard_cursor_nav: four parameter variants share one stimulus stream;
// expectations are queued at drive time and compared when each command lands.
`timescale 1ns/1ps
module tb_keyboard_cursor_nav;

  localparam int N = 4;
  // Variants: 0 default wrap, 1 saturate, 2 step2/ymax7 wrap, 3 step2/ymax7 saturate.
  localparam int P_STEP  [N] = '{1, 1, 2, 2};
  localparam int P_WRAP  [N] = '{1, 0, 1, 0};
  localparam int P_YMAX  [N] = '{4, 4, 7, 7};
  localparam int P_HOMEY [N] = '{1, 1, 6, 6};
  localparam int P_XMIN = 1;
  localparam int P_XMAX = 4;
  localparam int P_YMIN = 1;
  localparam int P_HOMEX = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] x_o   [N];
  logic [7:0] y_o   [N];
  logic       mv_o  [N];
  logic       sel_o [N];
  logic       ovf_o [N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int ex [N];
    int ey [N];
    bit mv [N];
    bit sel;
  } exp_t;

  exp_t sb [$];
  int   mx [N];
  int   my [N];
  int   ex_x [N];
  int   ex_y [N];
  bit   cmv  [N];
  bit   csel;
  exp_t cur_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keyboard_cursor_nav dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clr_ovf(clr_ovf),
    .x(x_o[0]), .y(y_o[0]), .move_pulse(mv_o[0]), .sel_pulse(sel_o[0]), .overflow(ovf_o[0]));

  keyboard_cursor_nav #(.WRAP(0)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clr_ovf(clr_ovf),
    .x(x_o[1]), .y(y_o[1]), .move_pulse(mv_o[1]), .sel_pulse(sel_o[1]), .overflow(ovf_o[1]));

  keyboard_cursor_nav #(.STEP(2), .Y_MAX(7), .HOME_Y(6), .WRAP(1)) dut2 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clr_ovf(clr_ovf),
    .x(x_o[2]), .y(y_o[2]), .move_pulse(mv_o[2]), .sel_pulse(sel_o[2]), .overflow(ovf_o[2]));

  keyboard_cursor_nav #(.STEP(2), .Y_MAX(7), .HOME_Y(6), .WRAP(0)) dut3 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clr_ovf(clr_ovf),
    .x(x_o[3]), .y(y_o[3]), .move_pulse(mv_o[3]), .sel_pulse(sel_o[3]), .overflow(ovf_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int nxt(input int v, input bit up, input int step,
                             input int lo, input int hi, input bit wrap);
    if (up) return (v + step > hi) ? (wrap ? lo : hi) : v + step;
    return (v < lo + step) ? (wrap ? hi : lo) : v - step;
  endfunction

  task automatic model_home();
    for (int i = 0; i < N; i++) begin
      mx[i] = P_HOMEX;
      my[i] = P_HOMEY[i];
    end
  endtask

  // Reference behaviour for one key across all variants, queued for cycle 'due'.
  task automatic expect_key(input logic [7:0] b, input int due);
    exp_t e;
    logic [7:0] u;
    int nx, ny;
    u = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
    e.due = due;
    e.sel = (b == 8'h20);
    for (int i = 0; i < N; i++) begin
      nx = mx[i];
      ny = my[i];
      case (u)
        8'h57: ny = nxt(my[i], 1'b1, P_STEP[i], P_YMIN, P_YMAX[i], P_WRAP[i] != 0);
        8'h53: ny = nxt(my[i], 1'b0, P_STEP[i], P_YMIN, P_YMAX[i], P_WRAP[i] != 0);
        8'h44: nx = nxt(mx[i], 1'b1, P_STEP[i], P_XMIN, P_XMAX, P_WRAP[i] != 0);
        8'h41: nx = nxt(mx[i], 1'b0, P_STEP[i], P_XMIN, P_XMAX, P_WRAP[i] != 0);
        8'h52: begin nx = P_HOMEX; ny = P_HOMEY[i]; end
        default: ;
      endcase
      e.mv[i] = (nx != mx[i]) || (ny != my[i]);
      e.ex[i] = nx;
      e.ey[i] = ny;
      mx[i] = nx;
      my[i] = ny;
    end
    sb.push_back(e);
  endtask

  // Monitor: compare every cycle; pulses must be 0 unless a queued command is due.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ex_x[i] = P_HOMEX;
        ex_y[i] = P_HOMEY[i];
      end
    end else begin
      csel = 1'b0;
      for (int i = 0; i < N; i++) cmv[i] = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        cur_e = sb.pop_front();
        csel = cur_e.sel;
        for (int i = 0; i < N; i++) begin
          ex_x[i] = cur_e.ex[i];
          ex_y[i] = cur_e.ey[i];
          cmv[i]  = cur_e.mv[i];
        end
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("x[%0d]@%0d", i, cyc), 32'(x_o[i]), 32'(ex_x[i]));
        chk($sformatf("y[%0d]@%0d", i, cyc), 32'(y_o[i]), 32'(ex_y[i]));
        chk($sformatf("move[%0d]@%0d", i, cyc), 32'(mv_o[i]), 32'(cmv[i]));
        chk($sformatf("sel[%0d]@%0d", i, cyc), 32'(sel_o[i]), 32'(csel));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    model_home();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    expect_key(b, cyc + 3);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic drive_raw(input logic [7:0] b, input logic v, input logic clr);
    rx_valid = v;
    rx_data  = b;
    clr_ovf  = clr;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string tag, input logic v);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), 32'(ovf_o[i]), 32'(v));
  endtask

  task automatic stall(input bit on);
    if (on) begin
      force dut0.pop_c = 1'b0;
      force dut1.pop_c = 1'b0;
      force dut2.pop_c = 1'b0;
      force dut3.pop_c = 1'b0;
    end else begin
      release dut0.pop_c;
      release dut1.pop_c;
      release dut2.pop_c;
      release dut3.pop_c;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_home();
    do_reset();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_x[%0d]", i), 32'(x_o[i]), 32'(P_HOMEX));
      chk($sformatf("rst_y[%0d]", i), 32'(y_o[i]), 32'(P_HOMEY[i]));
    end
    chk_ovf("rst_ovf", 1'b0);

    // 1: four back-to-back 'd' keys
    for (int k = 0; k < 4; k++) send(8'h64);
    drain();
    chk("t1_x_wrap", 32'(x_o[0]), 32'd1);
    chk("t1_x_sat", 32'(x_o[1]), 32'd4);

    // 2: left at the edge, then 'w' x5
    do_reset();
    send(8'h41);
    for (int k = 0; k < 5; k++) send(8'h77);
    drain();
    chk("t2_x_sat", 32'(x_o[1]), 32'd1);
    chk("t2_y_sat", 32'(y_o[1]), 32'd4);

    // 3: step 2 from y=6 with Y_MAX=7
    do_reset();
    send(8'h57);
    drain();
    chk("t3_y_wrap", 32'(y_o[2]), 32'd1);
    chk("t3_y_sat", 32'(y_o[3]), 32'd7);

    // 4: stalled pops, overflow on the 5th byte, set beats clear
    do_reset();
    stall(1'b1);
    for (int k = 0; k < 4; k++) drive_raw(8'h64, 1'b1, 1'b0);
    chk_ovf("t4_ovf_full", 1'b0);
    drive_raw(8'h77, 1'b1, 1'b0);
    chk_ovf("t4_ovf_drop", 1'b1);
    drive_raw(8'h77, 1'b1, 1'b1);
    chk_ovf("t4_ovf_setwins", 1'b1);
    drive_raw(8'h00, 1'b0, 1'b1);
    chk_ovf("t4_ovf_clr", 1'b0);
    r = cyc;
    stall(1'b0);
    for (int k = 0; k < 4; k++) expect_key(8'h64, r + 2 + k);
    drain();
    chk("t4_y_lost", 32'(y_o[0]), 32'd1);

    // 5: s, r, space, A, then an unmapped key
    do_reset();
    send(8'h73);
    send(8'h72);
    send(8'h20);
    send(8'h41);
    send(8'h7A);
    drain();
    chk("t5_x_wrap", 32'(x_o[0]), 32'd4);

    // 6: async reset with three keys buffered
    send(8'h77);
    drain();
    stall(1'b1);
    drive_raw(8'h64, 1'b1, 1'b0);
    drive_raw(8'h77, 1'b1, 1'b0);
    drive_raw(8'h64, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t6_x[%0d]", i), 32'(x_o[i]), 32'(P_HOMEX));
      chk($sformatf("t6_y[%0d]", i), 32'(y_o[i]), 32'(P_HOMEY[i]));
      chk($sformatf("t6_mv[%0d]", i), 32'(mv_o[i]), 32'd0);
    end
    chk_ovf("t6_ovf", 1'b0);
    sb.delete();
    model_home();
    stall(1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t6_x_still", 32'(x_o[0]), 32'd1);
    chk("t6_y_still", 32'(y_o[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
